// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM driver: channel indices, default
// resolution and the input buffer state encoding.
package rgb_pkg;

   localparam int R = 0;
   localparam int G = 1;
   localparam int B = 2;

   localparam int DEF_WIDTH = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/rgb_pwm_if.sv
// Duty-triple handshake between the colour/pattern logic and rgb_pwm.
interface rgb_pwm_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_r;
   logic [WIDTH-1:0] in_g;
   logic [WIDTH-1:0] in_b;

   modport master (
      output in_valid,
      output in_r,
      output in_g,
      output in_b,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_r,
      input  in_g,
      input  in_b,
      output in_ready
   );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, comparator against the shared
// phase and the polarity-adjusted pin flop.
module pwm_channel
   import rgb_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] duty_next,
   input  logic [WIDTH-1:0] phase,
   output logic             pin
);

   logic [WIDTH-1:0] active_r;
   logic             lit_s;
   logic             pin_r;

   // Lit while the shared phase is below this channel's duty.
   always_comb begin
      lit_s = 1'b0;
      if (enable && (phase < active_r)) begin
         lit_s = 1'b1;
      end else begin
         lit_s = 1'b0;
      end
   end

   // Active duty register, reloaded from the pending buffer on load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_r <= {WIDTH{1'b0}};
      end else if (load) begin
         active_r <= duty_next;
      end
   end

   // Registered pin drive with polarity applied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pin_r <= ACTIVE_LOW;
      end else begin
         pin_r <= lit_s ^ ACTIVE_LOW;
      end
   end

   assign pin = pin_r;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM LED driver with a double-buffered duty triple that is
// applied only at period boundaries so colour changes never glitch.
module rgb_pwm
   import rgb_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE   = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    enable,
   rgb_pwm_if.slave bus,
   output logic    red,
   output logic    green,
   output logic    blue,
   output logic    period_start
);

   localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] PHASE_LAST = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] PHASE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [PW-1:0]    presc_r;
   logic [WIDTH-1:0] phase_r;
   buf_state_e       state_r;
   logic [WIDTH-1:0] pending_r [3];
   logic             period_start_r;
   logic             step_s;
   logic             boundary_s;
   logic             load_s;
   logic [2:0]       pin_s;

   // Step and boundary strobes, plus the pending-to-active load strobe.
   always_comb begin
      step_s     = 1'b0;
      boundary_s = 1'b0;
      load_s     = 1'b0;
      if (enable && (presc_r == PRESC_LAST)) begin
         step_s = 1'b1;
      end else begin
         step_s = 1'b0;
      end
      if (step_s && (phase_r == PHASE_LAST)) begin
         boundary_s = 1'b1;
      end else begin
         boundary_s = 1'b0;
      end
      if ((state_r == FULL) && (boundary_s || !enable)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Prescaler: counts clocks per PWM step, held at zero while disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_r <= {PW{1'b0}};
      end else if (!enable || (presc_r == PRESC_LAST)) begin
         presc_r <= {PW{1'b0}};
      end else begin
         presc_r <= presc_r + PRESC_ONE;
      end
   end

   // Phase counter: wraps modulo 2^WIDTH, restarts from zero on re-enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_r <= {WIDTH{1'b0}};
      end else if (!enable) begin
         phase_r <= {WIDTH{1'b0}};
      end else if (step_s) begin
         phase_r <= phase_r + PHASE_ONE;
      end
   end

   // Buffer FSM: EMPTY accepts a triple, FULL drains at a boundary or while disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= EMPTY;
         pending_r <= '{default: {WIDTH{1'b0}}};
      end else begin
         case (state_r)
            EMPTY: begin
               if (bus.in_valid) begin
                  state_r      <= FULL;
                  pending_r[R] <= bus.in_r;
                  pending_r[G] <= bus.in_g;
                  pending_r[B] <= bus.in_b;
               end
            end
            FULL: begin
               if (boundary_s || !enable) begin
                  state_r <= EMPTY;
               end
            end
            default: begin
               state_r <= EMPTY;
            end
         endcase
      end
   end

   // Period start pulse, one cycle after the first enabled cycle of a period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_start_r <= 1'b0;
      end else begin
         period_start_r <= enable && (presc_r == {PW{1'b0}}) && (phase_r == {WIDTH{1'b0}});
      end
   end

   assign bus.in_ready = (state_r == EMPTY);
   assign period_start = period_start_r;

   for (genvar c = 0; c < 3; c++) begin : g_ch
      pwm_channel #(
         .WIDTH      (WIDTH),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .enable    (enable),
         .load      (load_s),
         .duty_next (pending_r[c]),
         .phase     (phase_r),
         .pin       (pin_s[c])
      );
   end

   assign red   = pin_s[R];
   assign green = pin_s[G];
   assign blue  = pin_s[B];

endmodule

// File: doc/rgb_pwm.md
# rgb_pwm

Three-channel PWM driver for the board RGB LED. It accepts 8-bit-class duty values for red, green and blue over a valid/ready handshake and double-buffers them. New values are applied only at PWM period boundaries, so colour changes never glitch mid-period. It sits downstream of the colour/pattern logic in `top` and drives the `red`, `green` and `blue` pins directly.

## Interface

Parameters:
- `WIDTH`, 8: duty and phase resolution in bits; period is 2^WIDTH steps.
- `PRESCALE`, 16: clocks per PWM step; must be ≥1.
- `ACTIVE_LOW`, 1: 1 means the pins sink current (LED on = 0).

Ports:
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: run PWM; low forces outputs off and holds the counters.
- `in_valid`  in  1: duty triple presented.
- `in_ready`  out  1: pending buffer empty.
- `in_r`, `in_g`, `in_b`  in  WIDTH: duty values; channel is lit for value/2^WIDTH of the period.
- `red`, `green`, `blue`  out  1: registered LED pin drives.
- `period_start`  out  1: one-cycle pulse on the first cycle of each period.

## Operation

Counters:
- `presc` counts 0..PRESCALE-1 and wraps to 0.
- `step` = enable && presc==PRESCALE-1.
- `phase` (WIDTH bits) increments on `step`; it wraps from 2^WIDTH-1 to 0 with modulo arithmetic, no saturation.
- `boundary` = step && phase==2^WIDTH-1.

Buffering:
- The buffer is a 2-state machine, EMPTY/FULL, with `in_ready` = (state==EMPTY), combinational.
- EMPTY→FULL on in_valid && in_ready; `pending` latches {in_r, in_g, in_b}.
- FULL→EMPTY on `boundary` or on any cycle with enable=0; `active` <= `pending` on that transition.
- A transfer in the same cycle as a boundary while EMPTY goes into `pending` only. It is not bypassed and applies at the next boundary.

Channel output:
- Channel lit when enable && phase < active_duty.
- Duty 0 means never lit. Duty 2^WIDTH-1 means lit for all but one step.
- The pin is registered and XORed with ACTIVE_LOW.

Enable:
- enable=0 synchronously clears `presc` and `phase` and drives pins inactive.
- The handshake still operates while enable=0.

Reset values:
- `presc`=0, `phase`=0, all `active`=0, `pending`=0, state EMPTY.
- `in_ready`=1.
- Pins inactive: 1 when ACTIVE_LOW=1, else 0.
- `period_start`=0.

## Timing

- Period = PRESCALE·2^WIDTH clocks; a channel with duty d is lit for d·PRESCALE clocks per period.
- Pins lag the internal phase/duty comparison by one cycle (registered).
- `period_start` is registered. It is high in the cycle after presc==0 && phase==0 && enable is first observed, i.e. one cycle after each boundary and one cycle after enable rises.
- Accept-to-visible latency is from the handshake to the first boundary after it, plus 1 cycle. The maximum is PRESCALE·2^WIDTH + 1 clocks.
- Back-to-back transfers: the second transfer stalls (in_ready=0) until the cycle after the boundary.
- Reset assertion takes effect immediately with no clock needed: pins inactive and pending data dropped. Deassertion is synchronised externally. The first period starts on the first enabled clock.

## Structure

- Shared package `rgb_pkg`:
  - Channel index constants R=0, G=1, B=2.
  - Default `WIDTH`.
  - Buffer state encoding EMPTY=0, FULL=1.
- One natural sub-module, `pwm_channel`, instantiated three times. It holds:
  - the active duty register, loaded via a `load` strobe;
  - the comparator against the shared `phase`;
  - the polarity-adjusted output flop.
- Prescaler, phase counter, buffer FSM and `period_start` live in `rgb_pwm`.

## Test plan

All scenarios use WIDTH=4, PRESCALE=2, ACTIVE_LOW=1, so the period is 32 clocks.

- **Reset:** reset low, then high, with enable=0 → red/green/blue=1, in_ready=1, period_start=0. Pins stay 1 until data is loaded.
- **Load and apply:** enable=0, send r=8, g=0, b=15; raise enable → period_start pulses every 32 clocks. red=0 for 16 clocks of each 32, green always 1, blue=0 for 30 clocks.
- **Backpressure:** while running with a pending value, present a second triple → in_ready=0 until the cycle after the boundary. The first triple is visible one period before the second.
- **Boundary collision:** transfer r=4 in exactly the boundary cycle, pending EMPTY → old duty kept for one full period. The new duty (8 lit clocks) appears after the following boundary.
- **Enable drop mid-period:** enable low at phase 5 → pins go to 1 next cycle. On re-enable, period_start fires after 1 cycle and phase restarts from 0.
- **Async reset mid-period:** reset asserted at phase 9 with pending FULL → pins 1 immediately, in_ready=1. After release, active duties are 0 and no LED lights.
